// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: shared types and defaults for the store monitor
package store_monitor_pkg;

    // One captured store transaction as seen on the core memory bus
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } store_entry_t;

    localparam int STORE_MONITOR_DEPTH = 4;

endpackage

// File: rtl/store_fifo.sv
// store_fifo: synchronous FIFO of store entries with a registered head
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and entry (dropped when full unless popping)
//   pop          consume the head entry (ignored when empty)
//   full, empty  occupancy flags
//   head         registered head entry; holds its last value once empty
module store_fifo
    import store_monitor_pkg::*;
#(
    parameter int DEPTH = STORE_MONITOR_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  store_entry_t din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output store_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    store_entry_t  mem [DEPTH];
    store_entry_t  head_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]   count, count_nxt;
    logic          push_ok, pop_ok;

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    assign pop_ok    = pop & ~empty;
    // A pop frees the slot the push lands in, so full+push+pop is legal
    assign push_ok   = push & (~full | pop_ok);
    assign rd_nxt    = rd_ptr + AW'(pop_ok);
    assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    // The next head may be the entry being written this very cycle
    always_comb head_nxt = (push_ok && rd_nxt == wr_ptr) ? din : mem[rd_nxt];

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) head <= head_nxt;
        end

endmodule

// File: rtl/store_monitor.sv
// store_monitor: captures accepted stores from the core bus, queues them for the checker, runs a watchdog
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_valid/ready/instr         core bus handshake and fetch flag
//   mem_addr/wdata/wstrb          core bus address, store data, byte strobes (0 = load)
//   check_ready                   checker takes the head entry
//   check_valid/instr/addr/       head entry presented to the checker
//   check_wdata/wstrb
//   overflow                      sticky: a store was dropped on a full FIFO
//   timeout                       sticky: no store captured for TIMEOUT cycles
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int          DEPTH        = STORE_MONITOR_DEPTH,
    parameter logic [31:0] TIMEOUT      = 32'd10000000,
    parameter bit          FILTER_INSTR = 1'b1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        mem_valid,
    input  logic        mem_ready,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        check_ready,
    output logic        check_valid,
    output logic        check_instr,
    output logic [31:0] check_addr,
    output logic [31:0] check_wdata,
    output logic [3:0]  check_wstrb,
    output logic        overflow,
    output logic        timeout
);

    store_entry_t head;
    logic         capture, pop, full, empty;
    logic [31:0]  wd, wd_nxt;

    assign capture = mem_valid & mem_ready & (|mem_wstrb) & ~(FILTER_INSTR & mem_instr);
    assign pop     = check_valid & check_ready;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   ('{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign check_valid = ~empty;
    assign {check_instr, check_addr, check_wdata, check_wstrb} = head;

    // Watchdog saturates at TIMEOUT; the flag is set on the edge it gets there
    assign wd_nxt = capture ? '0 : (wd == TIMEOUT ? wd : wd + 32'd1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wd       <= '0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wd       <= wd_nxt;
            timeout  <= timeout | (wd_nxt == TIMEOUT);
            overflow <= overflow | (capture & full & ~pop);
        end

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: scoreboard bench for store_monitor with directed vectors
module tb_store_monitor;
    import store_monitor_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid = 1'b0, mem_ready = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        check_ready = 1'b0;
    logic        check_valid, check_instr, overflow, timeout;
    logic [31:0] check_addr, check_wdata;
    logic [3:0]  check_wstrb;

    store_entry_t exp_q[$];
    int checks = 0, passed = 0;

    store_monitor #(.DEPTH(4), .TIMEOUT(32'd16), .FILTER_INSTR(1'b1)) dut (
        .rst(rst), .clk(clk),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .check_ready(check_ready), .check_valid(check_valid), .check_instr(check_instr),
        .check_addr(check_addr), .check_wdata(check_wdata), .check_wstrb(check_wstrb),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every pop the DUT will perform at the next edge is compared against the queue
    always @(negedge clk) begin
        store_entry_t e;
        if (!rst && check_valid && check_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pop: got addr %h expected no entry", check_addr);
            end else begin
                e = exp_q.pop_front();
                chk("pop_instr", 32'(check_instr), 32'(e.instr));
                chk("pop_addr", check_addr, e.addr);
                chk("pop_wdata", check_wdata, e.wdata);
                chk("pop_wstrb", 32'(check_wstrb), 32'(e.wstrb));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_ready = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    endtask

    // Drive one bus beat for one cycle; queue it when it is expected at the checker
    task automatic beat(input logic v, input logic r, input logic ins, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit expect_out);
        mem_valid = v; mem_ready = r; mem_instr = ins;
        mem_addr = a; mem_wdata = d; mem_wstrb = s;
        if (expect_out) exp_q.push_back('{instr: ins, addr: a, wdata: d, wstrb: s});
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        chk("rst_valid", 32'(check_valid), 0);
        chk("rst_instr", 32'(check_instr), 0);
        chk("rst_addr", check_addr, 0);
        chk("rst_wdata", check_wdata, 0);
        chk("rst_wstrb", 32'(check_wstrb), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // 1/2: reset, idle, single store
        check_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        chk("idle_valid", 32'(check_valid), 0);
        beat(1, 1, 0, 32'h0000_1000, 32'h1, 4'hF, 1);
        idle();
        chk("single_valid", 32'(check_valid), 1);
        chk("single_addr", check_addr, 32'h0000_1000);
        tick();
        chk("single_hold", check_wdata, 32'h1);
        check_ready = 1'b1;
        tick();
        chk("single_drained", 32'(check_valid), 0);
        chk("single_hold_addr", check_addr, 32'h0000_1000);
        // 3: fetch, load and unaccepted store neither capture nor clear the watchdog
        beat(1, 1, 0, 32'h0000_2000, 32'h2, 4'hF, 1);
        idle();
        beat(1, 1, 1, 32'h0000_3000, 32'h3, 4'hF, 0);
        beat(1, 1, 0, 32'h0000_3004, 32'h4, 4'h0, 0);
        beat(1, 0, 0, 32'h0000_3008, 32'h5, 4'hF, 0);
        idle();
        repeat (12) tick();
        chk("filter_wd_before", 32'(timeout), 0);
        chk("filter_valid", 32'(check_valid), 0);
        tick();
        chk("filter_wd_at", 32'(timeout), 1);
        // 4: stall and fill, fifth store dropped
        check_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++)
            beat(1, 1, 0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'h3, i < 4);
        idle();
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_head", check_addr, 32'h10);
        check_ready = 1'b1;
        repeat (4) tick();
        chk("fill_drained_q", exp_q.size(), 0);
        chk("fill_drained_valid", 32'(check_valid), 0);
        // 5: full with simultaneous push and pop
        check_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++)
            beat(1, 1, 0, 32'h50 + 32'(4 * i), 32'hB0 + 32'(i), 4'hC, 1);
        check_ready = 1'b1;
        beat(1, 1, 0, 32'h40, 32'hC0, 4'h1, 1);
        idle();
        repeat (4) tick();
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_drained_q", exp_q.size(), 0);
        chk("pp_valid", 32'(check_valid), 0);
        // 6: watchdog from reset release, sticky across a store, then async mid-stream reset
        do_reset();
        repeat (15) tick();
        chk("wd_15", 32'(timeout), 0);
        tick();
        chk("wd_16", 32'(timeout), 1);
        beat(1, 1, 0, 32'h77, 32'h77, 4'hF, 1);
        idle();
        tick();
        chk("wd_sticky", 32'(timeout), 1);
        check_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(1, 1, 0, 32'h80 + 32'(4 * i), 32'(i), 4'hF, 0);
        idle();
        chk("mid_overflow_set", 32'(overflow), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(check_valid), 0);
        chk("async_overflow", 32'(overflow), 0);
        chk("async_timeout", 32'(timeout), 0);
        do_reset();
        tick();
        chk("mid_after_valid", 32'(check_valid), 0);
        chk("final_q", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
